// File: rtl/key_entry_controller_if.sv
// key_entry_controller_if
// Groups the key-pulse input and the status/display outputs of the key entry
// controller into one bundle. The clock and reset stay as plain ports on the modules.
//   keyPulse   [4] valid strobe, [3:0] key value (driven by the debouncer side)
//   unlocked   high in OPEN and PROGRAM
//   lockedOut  high in LOCKOUT
//   error      one-cycle pulse on a failed check or a short program entry
//   digitCount digits currently held in the entry buffer
//   entryBuf   entry shift buffer, newest digit in [3:0]
//   state      IDLE=0 ENTRY=1 CHECK=2 OPEN=3 PROGRAM=4 LOCKOUT=5
interface key_entry_controller_if #(
    parameter int DIGITS = 4
) ();
    logic [4:0]          keyPulse;
    logic                unlocked;
    logic                lockedOut;
    logic                error;
    logic [2:0]          digitCount;
    logic [4*DIGITS-1:0] entryBuf;
    logic [2:0]          state;

    // Upstream side: sends key pulses and observes status.
    modport master (
        output keyPulse,
        input  unlocked, lockedOut, error, digitCount, entryBuf, state
    );

    // Controller side: consumes key pulses and drives status.
    modport slave (
        input  keyPulse,
        output unlocked, lockedOut, error, digitCount, entryBuf, state
    );
endinterface

// File: rtl/key_entry_controller.sv
// key_entry_controller
// Collects debounced key pulses into a multi-digit code, checks it against the
// stored code, drives lock/unlock status, locks the keypad out for a fixed time
// after too many consecutive failures, and lets the code be reprogrammed while
// unlocked. Every output is a register.
// Ports:
//   newClock  sole clock, rising edge
//   reset     asynchronous, active-high
//   bus       key_entry_controller_if.slave (keyPulse in; unlocked, lockedOut,
//             error, digitCount, entryBuf, state out)
module key_entry_controller #(
    parameter int                  DIGITS   = 4,
    parameter logic [4*DIGITS-1:0] CODE     = 16'h1234,
    parameter int                  TIMEOUT  = 50,
    parameter int                  MAX_FAIL = 3,
    parameter int                  LOCKOUT  = 200
) (
    input  logic                   newClock,
    input  logic                   reset,
    key_entry_controller_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCKOUT + 1);

    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_PROG  = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_PROGRAM = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t         state_r, state_n;
    logic [BW-1:0]  buf_r, buf_n;
    logic [2:0]     cnt_r, cnt_n;
    logic [BW-1:0]  code_r, code_n;
    logic [FW-1:0]  fail_r, fail_n;
    logic [IW-1:0]  idle_r, idle_n;
    logic [LW-1:0]  lock_r, lock_n;
    logic           error_r, error_n;
    logic           unlocked_r;
    logic           locked_r;

    // Key decode and shared datapath helpers.
    logic           key_valid_s;
    logic [3:0]     key_val_s;
    logic           is_digit_s;
    logic           is_clear_s;
    logic           is_enter_s;
    logic           is_prog_s;
    logic           buf_full_s;
    logic [BW-1:0]  shift_buf_s;
    logic [BW-1:0]  take_buf_s;
    logic [2:0]     take_cnt_s;
    logic           timeout_s;
    logic           match_s;
    logic [FW-1:0]  fail_inc_s;

    assign key_valid_s = bus.keyPulse[4];
    assign key_val_s   = bus.keyPulse[3:0];
    assign is_digit_s  = key_valid_s && (key_val_s <= 4'd9);
    assign is_clear_s  = key_valid_s && (key_val_s == KEY_CLEAR);
    assign is_enter_s  = key_valid_s && (key_val_s == KEY_ENTER);
    assign is_prog_s   = key_valid_s && (key_val_s == KEY_PROG);

    // A full buffer silently drops further digits rather than shifting out the oldest.
    assign buf_full_s  = (cnt_r == 3'(DIGITS));
    assign shift_buf_s = (buf_r << 3'd4) | BW'(key_val_s);
    assign take_buf_s  = buf_full_s ? buf_r : shift_buf_s;
    assign take_cnt_s  = buf_full_s ? cnt_r : (cnt_r + 3'd1);

    // The counter holds the number of quiet cycles already seen; the edge that
    // would make it TIMEOUT is the abandon edge.
    assign timeout_s   = (idle_r == IW'(TIMEOUT - 1));
    assign match_s     = buf_full_s && (buf_r == code_r);
    assign fail_inc_s  = fail_r + FW'(1);

    // Next-state and datapath decisions for every state.
    always_comb begin
        state_n = state_r;
        buf_n   = buf_r;
        cnt_n   = cnt_r;
        code_n  = code_r;
        fail_n  = fail_r;
        idle_n  = {IW{1'b0}};
        lock_n  = lock_r;
        error_n = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (is_digit_s) begin
                    buf_n   = take_buf_s;
                    cnt_n   = take_cnt_s;
                    state_n = S_ENTRY;
                end else begin
                    state_n = S_IDLE;
                end
            end

            S_ENTRY: begin
                if (key_valid_s) begin
                    if (is_digit_s) begin
                        buf_n = take_buf_s;
                        cnt_n = take_cnt_s;
                    end else if (is_clear_s) begin
                        buf_n   = {BW{1'b0}};
                        cnt_n   = 3'd0;
                        state_n = S_IDLE;
                    end else if (is_enter_s) begin
                        state_n = S_CHECK;
                    end else begin
                        state_n = S_ENTRY;
                    end
                end else if (timeout_s) begin
                    // Abandoned entry: not counted as a failure.
                    buf_n   = {BW{1'b0}};
                    cnt_n   = 3'd0;
                    state_n = S_IDLE;
                end else begin
                    idle_n = idle_r + IW'(1);
                end
            end

            S_CHECK: begin
                buf_n = {BW{1'b0}};
                cnt_n = 3'd0;
                if (match_s) begin
                    fail_n  = {FW{1'b0}};
                    state_n = S_OPEN;
                end else begin
                    error_n = 1'b1;
                    fail_n  = fail_inc_s;
                    if (fail_inc_s == FW'(MAX_FAIL)) begin
                        lock_n  = LW'(LOCKOUT);
                        state_n = S_LOCKOUT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end

            S_OPEN: begin
                if (is_clear_s || is_enter_s) begin
                    state_n = S_IDLE;
                end else if (is_prog_s) begin
                    state_n = S_PROGRAM;
                end else begin
                    state_n = S_OPEN;
                end
            end

            S_PROGRAM: begin
                if (key_valid_s) begin
                    if (is_digit_s) begin
                        buf_n = take_buf_s;
                        cnt_n = take_cnt_s;
                    end else if (is_enter_s) begin
                        buf_n = {BW{1'b0}};
                        cnt_n = 3'd0;
                        if (buf_full_s) begin
                            code_n  = buf_r;
                            state_n = S_OPEN;
                        end else begin
                            error_n = 1'b1;
                            state_n = S_PROGRAM;
                        end
                    end else if (is_clear_s) begin
                        buf_n   = {BW{1'b0}};
                        cnt_n   = 3'd0;
                        state_n = S_OPEN;
                    end else begin
                        state_n = S_PROGRAM;
                    end
                end else if (timeout_s) begin
                    buf_n   = {BW{1'b0}};
                    cnt_n   = 3'd0;
                    state_n = S_OPEN;
                end else begin
                    idle_n = idle_r + IW'(1);
                end
            end

            S_LOCKOUT: begin
                // Timer is loaded with LOCKOUT on entry; the edge that sees 1 ends it.
                if (lock_r == LW'(1)) begin
                    lock_n  = {LW{1'b0}};
                    fail_n  = {FW{1'b0}};
                    state_n = S_IDLE;
                end else begin
                    lock_n  = lock_r - LW'(1);
                    state_n = S_LOCKOUT;
                end
            end

            default: begin
                buf_n   = {BW{1'b0}};
                cnt_n   = 3'd0;
                fail_n  = {FW{1'b0}};
                lock_n  = {LW{1'b0}};
                state_n = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge newClock or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            buf_r      <= {BW{1'b0}};
            cnt_r      <= 3'd0;
            code_r     <= CODE;
            fail_r     <= {FW{1'b0}};
            idle_r     <= {IW{1'b0}};
            lock_r     <= {LW{1'b0}};
            error_r    <= 1'b0;
            unlocked_r <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_n;
            buf_r      <= buf_n;
            cnt_r      <= cnt_n;
            code_r     <= code_n;
            fail_r     <= fail_n;
            idle_r     <= idle_n;
            lock_r     <= lock_n;
            error_r    <= error_n;
            unlocked_r <= (state_n == S_OPEN) || (state_n == S_PROGRAM);
            locked_r   <= (state_n == S_LOCKOUT);
        end
    end

    assign bus.state      = state_r;
    assign bus.entryBuf   = buf_r;
    assign bus.digitCount = cnt_r;
    assign bus.error      = error_r;
    assign bus.unlocked   = unlocked_r;
    assign bus.lockedOut  = locked_r;
endmodule

// File: tb/tb_key_entry_controller.sv
// tb_key_entry_controller
// Drives directed and randomized key pulses into key_entry_controller and
// compares every output after every clock edge against a reference model that
// keeps the entry as a queue of digits, the code as an array of digits, and the
// timers as absolute deadline cycle numbers.
module tb_key_entry_controller;
    localparam int          DIGITS   = 4;
    localparam logic [15:0] CODE     = 16'h1234;
    localparam int          TIMEOUT  = 50;
    localparam int          MAX_FAIL = 3;
    localparam int          LOCKOUT  = 200;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OPEN = 3, M_PROGRAM = 4, M_LOCKOUT = 5;

    logic newClock;
    logic reset;

    key_entry_controller_if #(.DIGITS(DIGITS)) bus ();

    key_entry_controller #(
        .DIGITS(DIGITS), .CODE(CODE), .TIMEOUT(TIMEOUT),
        .MAX_FAIL(MAX_FAIL), .LOCKOUT(LOCKOUT)
    ) dut (
        .newClock(newClock),
        .reset(reset),
        .bus(bus)
    );

    initial newClock = 1'b0;
    always #5 newClock = ~newClock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state.
    int m_state;
    int m_fail;
    int m_last;
    int m_lock_end;
    bit m_err;
    int m_q[$];
    int m_code[DIGITS];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] pack_q();
        logic [15:0] r;
        r = 16'h0;
        foreach (m_q[i]) r = (r << 4) | 16'(m_q[i] & 15);
        return r;
    endfunction

    task automatic model_reset();
        logic [15:0] c;
        c = CODE;
        m_state = M_IDLE;
        m_fail  = 0;
        m_err   = 1'b0;
        m_q.delete();
        for (int i = 0; i < DIGITS; i++) m_code[i] = int'((c >> (4 * (DIGITS - 1 - i))) & 16'hF);
    endtask

    task automatic push_digit(input int k);
        if (m_q.size() < DIGITS) m_q.push_back(k);
    endtask

    // Advance the model by one clock edge with the key sampled at that edge.
    task automatic model_edge(input bit v, input int k);
        bit match;
        m_err = 1'b0;
        case (m_state)
            M_IDLE: if (v && k <= 9) begin
                push_digit(k);
                m_last  = cyc;
                m_state = M_ENTRY;
            end
            M_ENTRY: begin
                if (v) begin
                    m_last = cyc;
                    if (k <= 9) push_digit(k);
                    else if (k == 12) begin m_q.delete(); m_state = M_IDLE; end
                    else if (k == 14) m_state = M_CHECK;
                end else if (cyc - m_last == TIMEOUT) begin
                    m_q.delete();
                    m_state = M_IDLE;
                end
            end
            M_CHECK: begin
                match = (m_q.size() == DIGITS);
                if (match) for (int i = 0; i < DIGITS; i++) if (m_q[i] != m_code[i]) match = 1'b0;
                m_q.delete();
                if (match) begin
                    m_fail  = 0;
                    m_state = M_OPEN;
                end else begin
                    m_err = 1'b1;
                    m_fail++;
                    if (m_fail == MAX_FAIL) begin
                        m_lock_end = cyc + LOCKOUT;
                        m_state    = M_LOCKOUT;
                    end else begin
                        m_state = M_IDLE;
                    end
                end
            end
            M_OPEN: begin
                if (v && (k == 12 || k == 14)) m_state = M_IDLE;
                else if (v && k == 10) begin m_state = M_PROGRAM; m_last = cyc; end
            end
            M_PROGRAM: begin
                if (v) begin
                    m_last = cyc;
                    if (k <= 9) push_digit(k);
                    else if (k == 14) begin
                        if (m_q.size() == DIGITS) begin
                            for (int i = 0; i < DIGITS; i++) m_code[i] = m_q[i];
                            m_state = M_OPEN;
                        end else begin
                            m_err = 1'b1;
                        end
                        m_q.delete();
                    end else if (k == 12) begin
                        m_q.delete();
                        m_state = M_OPEN;
                    end
                end else if (cyc - m_last == TIMEOUT) begin
                    m_q.delete();
                    m_state = M_OPEN;
                end
            end
            M_LOCKOUT: if (cyc == m_lock_end) begin
                m_fail  = 0;
                m_state = M_IDLE;
            end
            default: m_state = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check_val("state",      32'(bus.state),      32'(m_state));
        check_val("digitCount", 32'(bus.digitCount), 32'(m_q.size()));
        check_val("entryBuf",   32'(bus.entryBuf),   32'(pack_q()));
        check_val("unlocked",   32'(bus.unlocked),   32'(m_state == M_OPEN || m_state == M_PROGRAM));
        check_val("lockedOut",  32'(bus.lockedOut),  32'(m_state == M_LOCKOUT));
        check_val("error",      32'(bus.error),      32'(m_err));
    endtask

    // One clock: drive the key, let the edge happen, advance the model, compare.
    task automatic step(input bit v, input int k);
        bus.keyPulse = {v, 4'(k)};
        @(posedge newClock);
        cyc++;
        model_edge(v, k);
        #1;
        compare_all();
    endtask

    task automatic press(input int k);
        step(1'b1, k);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic enter_code(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d); press(14);
    endtask

    // Reset between edges; outputs must already be at reset values before the next edge.
    task automatic async_reset();
        bus.keyPulse = 5'd0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1 reset = 1'b0;
    endtask

    initial begin
        int op;
        int n;
        reset        = 1'b1;
        bus.keyPulse = 5'd0;
        model_reset();
        #12;
        compare_all();
        reset = 1'b0;

        // Correct code with gaps: CHECK one cycle, then OPEN.
        press(1); quiet(1); press(2); quiet(1); press(3); quiet(1); press(4); quiet(1);
        press(14); quiet(3);
        press(14); quiet(1);

        // Three wrong codes into lockout, keys ignored throughout, then IDLE.
        for (int t = 0; t < 3; t++) begin enter_code(1, 2, 3, 5); quiet(2); end
        for (int i = 0; i < LOCKOUT; i++) step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        quiet(2);

        // Fifth digit dropped, unlock; short code fails.
        press(1); press(2); press(3); press(4); press(5); press(14); quiet(2);
        press(12);
        press(1); press(2); press(14); quiet(2);

        // Reprogram, relock, new code works, old fails, reset restores old code.
        enter_code(1, 2, 3, 4); quiet(1);
        press(10); enter_code(9, 8, 7, 6); quiet(1);
        press(12); quiet(1);
        enter_code(9, 8, 7, 6); quiet(1);
        press(14);
        enter_code(1, 2, 3, 4); quiet(1);
        async_reset();
        enter_code(1, 2, 3, 4); quiet(1);

        // Short program entry, then program timeout back to OPEN.
        press(10); press(1); press(2); press(14); quiet(1);
        press(5); quiet(TIMEOUT + 2);
        press(14);

        // Entry timeout and clear.
        press(7); quiet(TIMEOUT + 2);
        press(7); press(12); quiet(1);

        // Reset in the middle of lockout and in the middle of entry.
        for (int t = 0; t < 3; t++) begin enter_code(5, 5, 5, 5); quiet(1); end
        quiet(LOCKOUT / 2);
        async_reset();
        press(1); press(2);
        async_reset();
        quiet(1);

        // Randomized phase.
        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 12));
            if (op <= 2) begin
                if (m_state == M_OPEN) press(14);
                for (int i = 0; i < DIGITS; i++) begin
                    press(m_code[i]);
                    quiet(int'($urandom_range(0, 2)));
                end
                press(14);
            end else if (op <= 4) begin
                n = int'($urandom_range(1, 6));
                for (int i = 0; i < n; i++) press(int'($urandom_range(0, 9)));
                press(14);
            end else if (op <= 6) begin
                n = int'($urandom_range(1, 10));
                for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            end else if (op <= 8) begin
                quiet(int'($urandom_range(1, TIMEOUT + 10)));
            end else if (op <= 10) begin
                press(10);
                n = int'($urandom_range(2, 5));
                for (int i = 0; i < n; i++) press(int'($urandom_range(0, 9)));
                press(($urandom_range(0, 3) == 0) ? 12 : 14);
            end else if (op == 11) begin
                press(int'($urandom_range(10, 15)));
            end else begin
                if ($urandom_range(0, 3) == 0) async_reset();
                else quiet(1);
            end
        end
        quiet(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/key_entry_controller.md
# key_entry_controller

Sequences debounced key pulses into a multi-digit code entry and checks the code against a stored value. Drives the lock/unlock status, counts failed attempts with a timed lockout, and allows the code to be reprogrammed while unlocked. It sits directly downstream of the key pulse debouncer, on the same `newClock` domain, and feeds the display and status LEDs.

## Interface

- `DIGITS`, 4: digits per code, 1..7.
- `CODE`, 16'h1234: reset value of the stored code, 4 bits per digit, most significant digit first; width 4*DIGITS.
- `TIMEOUT`, 50: idle `newClock` cycles allowed during entry before it is abandoned, ≥1.
- `MAX_FAIL`, 3: consecutive failed checks that trigger lockout, 1..7.
- `LOCKOUT`, 200: lockout duration in `newClock` cycles, ≥1.

- `newClock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `keyPulse` in 5: `[4]` is the valid strobe (one cycle per press); `[3:0]` is the key value.
- `unlocked` out 1: high in OPEN and PROGRAM.
- `lockedOut` out 1: high in LOCKOUT.
- `error` out 1: one-cycle pulse on a failed check or a short program entry.
- `digitCount` out 3: digits currently held in the buffer.
- `entryBuf` out 4*DIGITS: entry shift buffer, newest digit in `[3:0]`.
- `state` out 3: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, PROGRAM=4, LOCKOUT=5.

## Operation

**Key classes.** A key only counts when `keyPulse[4]`=1.
- Digits: values 0–9.
- Clear: 4'hC.
- Enter: 4'hE.
- Program: 4'hA.
- Every other value is ignored. If the strobe is held high, each cycle is a separate press.

**Shift-in.** Applies when `digitCount` < DIGITS: `entryBuf` ← {`entryBuf`[4*DIGITS-5:0], digit} and `digitCount`+1. At `digitCount` = DIGITS, further digits are ignored with no change.

**State behaviour.**
- **IDLE**
  - Digit: shift in, go to ENTRY.
  - Any other key: ignored.
- **ENTRY**
  - Digit: shift in.
  - Clear: buffer and count to 0, go to IDLE.
  - Enter: go to CHECK.
  - The idle counter resets on any valid pulse and increments otherwise. When it reaches TIMEOUT: buffer and count to 0, go to IDLE. A timeout is not a failure.
- **CHECK** (exactly one cycle; keys arriving in this cycle are ignored)
  - Match means `digitCount` = DIGITS and `entryBuf` = stored code.
  - Match: failure count to 0, go to OPEN.
  - No match: `error` pulses and the failure count increments. If the new count equals MAX_FAIL, load the lockout timer and go to LOCKOUT; otherwise go to IDLE.
  - The buffer and count are cleared on leaving CHECK in every case.
- **OPEN**
  - Enter or Clear: relock, go to IDLE.
  - Program: go to PROGRAM.
  - Digits: ignored.
- **PROGRAM**
  - Digit: shift in; the idle timeout applies as in ENTRY.
  - Enter with `digitCount` = DIGITS: stored code ← `entryBuf`, go to OPEN.
  - Enter with `digitCount` < DIGITS: `error` pulses, stay in PROGRAM.
  - Clear or timeout: go to OPEN with the stored code unchanged.
  - Every exit from PROGRAM, and every Enter press in it, clears the buffer and count.
- **LOCKOUT**
  - All keys are ignored.
  - The timer counts LOCKOUT cycles. At expiry the failure count goes to 0 and the state goes to IDLE.

**Widths and sizing.**
- Counter widths are sized with $clog2 of their terminal value plus 1.
- The failure counter never exceeds MAX_FAIL.

## Timing

- All outputs are registered and change only on a `newClock` rising edge or on `reset`.
- **Reset values:** `state`=IDLE, `unlocked`=0, `lockedOut`=0, `error`=0, `digitCount`=0, `entryBuf`=0, failure, idle and lockout counters = 0, stored code = CODE.
- **Reset mid-operation** aborts immediately: it ends any lockout and discards a reprogrammed code.
- **Key latency:** a pulse sampled at edge k is reflected in `entryBuf`, `digitCount` and `state` after edge k.
- **Enter latency:** Enter at edge k puts `state`=CHECK after k. The verdict is applied at k+1: `unlocked` or `error` goes high after k+1, and `error` is high for exactly one cycle.
- **Lockout duration:** LOCKOUT is entered at edge j; `lockedOut` stays high for exactly LOCKOUT cycles and `state`=IDLE after edge j+LOCKOUT.
- **Timeout:** the last pulse at edge p with no later pulses leads to the return (to IDLE from ENTRY, to OPEN from PROGRAM) after edge p+TIMEOUT.

## Test plan

- Reset, then pulses 1,2,3,4,E with one idle cycle between each → CHECK for one cycle, then OPEN, `unlocked`=1, `error` never high.
- Pulses 1,2,3,5,E three times → `error` pulses three times; after the third, `lockedOut`=1 for exactly 200 cycles with all keys ignored, then IDLE with the failure count at 0.
- Pulses 1,2,3,4,5,E → the fifth digit is ignored, `entryBuf`=16'h1234, unlock succeeds. Separately, pulses 1,2,E → `error` (short code).
- From OPEN: pulse A, then 9,8,7,6,E → OPEN; then C; then 9,8,7,6,E unlocks and 1,2,3,4,E fails. Assert `reset` → stored code returns to 16'h1234.
- Pulse 7, then 50 idle cycles → IDLE with `entryBuf`=0 and `error` low. Pulse 7, then C → IDLE immediately.
- Assert `reset` midway through LOCKOUT and midway through ENTRY → all outputs return to their reset values asynchronously, before the next `newClock` edge.
